// File: rtl/imsic_msi_queue_if.sv
// Bus and interrupt-file signals for imsic_msi_queue, grouped so the design and its
// environment share a single bundle. slave = queue side, master = bridge/file side.
//
// Handshakes: every valid/ready pair transfers exactly on a cycle where both are high.
// A source holding valid keeps its payload stable until that cycle.
interface imsic_msi_queue_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NR_SRC_LEN    = 11,
  parameter int NR_INTP_FILES = 4
);
  logic                                     i_req_valid;
  logic                                     o_req_ready;
  logic [ADDR_WIDTH-1:0]                    i_req_addr;
  logic                                     i_req_we;
  logic [DATA_WIDTH-1:0]                    i_req_wdata;
  logic                                     o_rsp_valid;
  logic                                     i_rsp_ready;
  logic [DATA_WIDTH-1:0]                    o_rsp_rdata;
  logic                                     o_rsp_err;
  logic [NR_INTP_FILES-1:0]                 o_setipnum_valid;
  logic [NR_INTP_FILES-1:0]                 i_setipnum_ready;
  logic [NR_INTP_FILES-1:0][NR_SRC_LEN-1:0] o_setipnum;
  logic [NR_INTP_FILES-1:0]                 o_overflow;
  logic [NR_INTP_FILES-1:0]                 i_overflow_clr;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_rsp_ready,
           i_setipnum_ready, i_overflow_clr,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_setipnum_valid, o_setipnum, o_overflow
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_rsp_ready,
           i_setipnum_ready, i_overflow_clr,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_setipnum_valid, o_setipnum, o_overflow
  );
endinterface

// File: rtl/imsic_msi_queue.sv
// Decodes MSI writes to the setipnum_le register of each interrupt file and queues
// the identities in a per-file FIFO drained over valid/ready. One bus request in flight.
module imsic_msi_queue #(
  parameter int                    NR_SRC_LEN    = 11,
  parameter int                    NR_SRC        = 64,
  parameter int                    NR_INTP_FILES = 4,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] M_BASE        = 32'h2400_0000,
  parameter logic [ADDR_WIDTH-1:0] S_BASE        = 32'h2800_0000,
  parameter logic [ADDR_WIDTH-1:0] FILE_STRIDE   = 32'h1000,
  parameter int                    FIFO_DEPTH    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  imsic_msi_queue_if.slave     bus,
  output logic                 o_dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  state_e state_q;
  logic   rsp_valid_q;
  logic   rsp_err_q;

  logic [NR_INTP_FILES-1:0] sel;
  logic                     hit;
  logic [NR_SRC_LEN-1:0]    id;
  logic                     id_ok;
  logic                     accept;
  logic [NR_INTP_FILES-1:0] enq;

  logic [NR_INTP_FILES-1:0][FIFO_DEPTH-1:0][NR_SRC_LEN-1:0] mem_q;
  logic [NR_INTP_FILES-1:0][PW-1:0]                         wr_ptr_q;
  logic [NR_INTP_FILES-1:0][PW-1:0]                         rd_ptr_q;
  logic [NR_INTP_FILES-1:0]                                 ovf_q;
  logic [NR_INTP_FILES-1:0] full, empty, deq, push, drop;

  function automatic logic [ADDR_WIDTH-1:0] file_addr(input int f);
    if (f == 0) return M_BASE;
    return S_BASE + ADDR_WIDTH'(f - 1) * FILE_STRIDE;
  endfunction

  // Full-address compare only, so aliases of a register never decode.
  always_comb begin
    sel = '0;
    for (int f = 0; f < NR_INTP_FILES; f++) begin
      if (bus.i_req_addr == file_addr(f)) sel[f] = 1'b1;
    end
  end

  assign hit    = |sel;
  assign id     = bus.i_req_wdata[NR_SRC_LEN-1:0];
  assign id_ok  = ((bus.i_req_wdata >> NR_SRC_LEN) == DATA_WIDTH'(0)) && (id != '0) &&
                  ({1'b0, id} < (NR_SRC_LEN + 1)'(NR_SRC));
  assign accept = bus.i_req_valid && bus.o_req_ready;
  assign enq    = (accept && bus.i_req_we && id_ok) ? sel : '0;

  assign bus.o_req_ready = (state_q == ST_IDLE) && !i_rst;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_err   = rsp_err_q;
  // setipnum_le reads as zero and error responses carry no data.
  assign bus.o_rsp_rdata = '0;
  assign o_dbg_state     = (state_q == ST_RESP);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !hit;
          end
        end
        ST_RESP: begin
          if (bus.i_rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pointers carry one extra bit so full and empty differ when indices match.
  always_comb begin
    for (int f = 0; f < NR_INTP_FILES; f++) begin
      empty[f] = (wr_ptr_q[f] == rd_ptr_q[f]);
      full[f]  = ((wr_ptr_q[f] - rd_ptr_q[f]) == PW'(FIFO_DEPTH));
      deq[f]   = !empty[f] && bus.i_setipnum_ready[f];
      push[f]  = enq[f] && (!full[f] || deq[f]);
      drop[f]  = enq[f] && full[f] && !deq[f];
      bus.o_setipnum_valid[f] = !empty[f];
      bus.o_setipnum[f]       = empty[f] ? '0 : mem_q[f][rd_ptr_q[f][PW-2:0]];
    end
  end

  assign bus.o_overflow = ovf_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= '0;
    end else begin
      for (int f = 0; f < NR_INTP_FILES; f++) begin
        if (push[f]) wr_ptr_q[f] <= wr_ptr_q[f] + PW'(1);
        if (deq[f])  rd_ptr_q[f] <= rd_ptr_q[f] + PW'(1);
        if (drop[f])                     ovf_q[f] <= 1'b1;
        else if (bus.i_overflow_clr[f])  ovf_q[f] <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero while a FIFO is empty.
  always_ff @(posedge i_clk) begin
    for (int f = 0; f < NR_INTP_FILES; f++) begin
      if (push[f]) mem_q[f][wr_ptr_q[f][PW-2:0]] <= id;
    end
  end

endmodule

// File: tb/tb_imsic_msi_queue.sv
// Bench for imsic_msi_queue: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a queue-based model of the queue.
module tb_imsic_msi_queue;

  localparam int          NR_SRC_LEN    = 11;
  localparam int          NR_SRC        = 64;
  localparam int          NF            = 4;
  localparam int          ADDR_WIDTH    = 32;
  localparam int          DATA_WIDTH    = 32;
  localparam logic [31:0] M_BASE        = 32'h2400_0000;
  localparam logic [31:0] S_BASE        = 32'h2800_0000;
  localparam logic [31:0] STRIDE        = 32'h1000;
  localparam int          DEPTH         = 4;
  localparam int          RAND_CYCLES   = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  always #5 clk = ~clk;

  imsic_msi_queue_if #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .NR_SRC_LEN(NR_SRC_LEN), .NR_INTP_FILES(NF)
  ) bif ();

  imsic_msi_queue #(
    .NR_SRC_LEN(NR_SRC_LEN), .NR_SRC(NR_SRC), .NR_INTP_FILES(NF),
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .M_BASE(M_BASE), .S_BASE(S_BASE), .FILE_STRIDE(STRIDE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bif.slave),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int tests  = 0;
  int errors = 0;

  logic [NR_SRC_LEN-1:0] exp_q[NF][$];
  bit                    m_ovf[NF];
  bit                    m_pend;
  bit                    m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int f = 0; f < NF; f++) begin
      exp_q[f].delete();
      m_ovf[f] = 1'b0;
    end
    m_pend = 1'b0;
    m_err  = 1'b0;
  endfunction

  // Returns the file selected by an address, or -1 if none.
  function automatic int decode(input logic [31:0] a);
    logic [31:0] d;
    if (a == M_BASE) return 0;
    d = a - S_BASE;
    if (a >= S_BASE && (d % STRIDE) == 0 && (d / STRIDE) < NF - 1) return 1 + int'(d / STRIDE);
    return -1;
  endfunction

  // Advance the model by one clock using the inputs the DUT saw at that edge.
  function automatic void model_step();
    bit acc;
    int fs;
    int enq_file;
    bit deq;
    bit dropped;
    if (rst) begin
      model_reset();
      return;
    end
    acc      = bif.i_req_valid && !m_pend;
    enq_file = -1;
    if (m_pend && bif.i_rsp_ready) begin
      m_pend = 1'b0;
      m_err  = 1'b0;
    end
    if (acc) begin
      fs     = decode(bif.i_req_addr);
      m_pend = 1'b1;
      m_err  = (fs < 0);
      if (bif.i_req_we && fs >= 0 && bif.i_req_wdata >= 1 && bif.i_req_wdata < NR_SRC)
        enq_file = fs;
    end
    for (int f = 0; f < NF; f++) begin
      deq     = (exp_q[f].size() > 0) && bif.i_setipnum_ready[f];
      dropped = 1'b0;
      if (deq) void'(exp_q[f].pop_front());
      if (f == enq_file) begin
        if (exp_q[f].size() < DEPTH) exp_q[f].push_back(bif.i_req_wdata[NR_SRC_LEN-1:0]);
        else dropped = 1'b1;
      end
      if (dropped) m_ovf[f] = 1'b1;
      else if (bif.i_overflow_clr[f]) m_ovf[f] = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    chk("req_ready", bif.o_req_ready, (!rst && !m_pend));
    chk("rsp_valid", bif.o_rsp_valid, m_pend);
    chk("rsp_err",   bif.o_rsp_err,   m_err);
    chk("rsp_rdata", bif.o_rsp_rdata, 0);
    chk("dbg_state", dbg_state,       m_pend);
    for (int f = 0; f < NF; f++) begin
      chk($sformatf("setipnum_valid[%0d]", f), bif.o_setipnum_valid[f], exp_q[f].size() > 0);
      chk($sformatf("setipnum[%0d]", f), bif.o_setipnum[f],
          (exp_q[f].size() > 0) ? exp_q[f][0] : 0);
      chk($sformatf("overflow[%0d]", f), bif.o_overflow[f], m_ovf[f]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic bus_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    bif.i_req_valid = 1'b1;
    bif.i_req_addr  = addr;
    bif.i_req_we    = we;
    bif.i_req_wdata = wdata;
    cycle();
    bif.i_req_valid = 1'b0;
  endtask

  task automatic bus_rsp(input int hold);
    for (int i = 0; i < hold; i++) begin
      cycle();
      chk("hold_req_ready", bif.o_req_ready, 0);
      chk("hold_rsp_valid", bif.o_rsp_valid, 1);
    end
    bif.i_rsp_ready = 1'b1;
    cycle();
    bif.i_rsp_ready = 1'b0;
  endtask

  task automatic pop_expect(input int f, input logic [NR_SRC_LEN-1:0] exp);
    chk($sformatf("pop_valid[%0d]", f), bif.o_setipnum_valid[f], 1);
    chk($sformatf("pop_id[%0d]", f), bif.o_setipnum[f], exp);
    bif.i_setipnum_ready[f] = 1'b1;
    cycle();
    bif.i_setipnum_ready[f] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] wd [3];
    rst                  = 1'b1;
    bif.i_req_valid      = 1'b0;
    bif.i_req_addr       = '0;
    bif.i_req_we         = 1'b0;
    bif.i_req_wdata      = '0;
    bif.i_rsp_ready      = 1'b0;
    bif.i_setipnum_ready = '0;
    bif.i_overflow_clr   = '0;
    model_reset();
    #1;
    chk("reset_req_ready", bif.o_req_ready, 0);
    check_outputs();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("idle_req_ready", bif.o_req_ready, 1);

    // single write to the M-level file and its pop
    bus_req(M_BASE, 1'b1, 32'h5);
    chk("m_rsp_valid", bif.o_rsp_valid, 1);
    chk("m_rsp_err", bif.o_rsp_err, 0);
    chk("m_head_valid", bif.o_setipnum_valid[0], 1);
    chk("m_head_id", bif.o_setipnum[0], 5);
    bif.i_setipnum_ready[0] = 1'b1;
    bus_rsp(0);
    bif.i_setipnum_ready[0] = 1'b0;
    chk("m_popped", bif.o_setipnum_valid[0], 0);

    // S/VS file decode, out-of-range file, read
    bus_req(S_BASE, 1'b1, 32'd7);              bus_rsp(0);
    bus_req(S_BASE + STRIDE, 1'b1, 32'd8);     bus_rsp(0);
    bus_req(S_BASE + 2 * STRIDE, 1'b1, 32'd9); bus_rsp(0);
    chk("f1_id", bif.o_setipnum[1], 7);
    chk("f2_id", bif.o_setipnum[2], 8);
    chk("f3_id", bif.o_setipnum[3], 9);
    bus_req(S_BASE + 3 * STRIDE, 1'b1, 32'd9);
    chk("bad_addr_err", bif.o_rsp_err, 1);
    bus_rsp(0);
    bus_req(S_BASE + STRIDE, 1'b0, 32'd0);
    chk("read_err", bif.o_rsp_err, 0);
    chk("read_rdata", bif.o_rsp_rdata, 0);
    bus_rsp(0);
    bif.i_setipnum_ready = '1;
    cycle();
    bif.i_setipnum_ready = '0;
    chk("drained", bif.o_setipnum_valid, 0);

    // identities that must be discarded silently
    wd[0] = 32'h0; wd[1] = 32'd64; wd[2] = 32'h1_0003;
    for (int i = 0; i < 3; i++) begin
      bus_req(M_BASE, 1'b1, wd[i]);
      chk($sformatf("bad_id_err_%0d", i), bif.o_rsp_err, 0);
      bus_rsp(0);
      chk($sformatf("bad_id_empty_%0d", i), bif.o_setipnum_valid[0], 0);
      chk($sformatf("bad_id_ovf_%0d", i), bif.o_overflow[0], 0);
    end

    // fill file 1 past capacity
    for (int i = 1; i <= 5; i++) begin
      bus_req(S_BASE, 1'b1, 32'(i));
      chk($sformatf("fill_err_%0d", i), bif.o_rsp_err, 0);
      bus_rsp(0);
    end
    chk("ovf_set", bif.o_overflow[1], 1);
    chk("ovf_head", bif.o_setipnum[1], 1);
    // enqueue while full, with a pop in the same cycle
    bif.i_setipnum_ready[1] = 1'b1;
    bus_req(S_BASE, 1'b1, 32'd6);
    bif.i_setipnum_ready[1] = 1'b0;
    chk("full_pop_head", bif.o_setipnum[1], 2);
    bus_rsp(0);
    // drop and clear in the same cycle: the drop wins
    bif.i_overflow_clr[1] = 1'b1;
    bus_req(S_BASE, 1'b1, 32'd7);
    bif.i_overflow_clr[1] = 1'b0;
    chk("ovf_clr_race", bif.o_overflow[1], 1);
    bus_rsp(0);
    bif.i_overflow_clr[1] = 1'b1;
    cycle();
    bif.i_overflow_clr[1] = 1'b0;
    chk("ovf_cleared", bif.o_overflow[1], 0);
    pop_expect(1, 2);
    pop_expect(1, 3);
    pop_expect(1, 4);
    pop_expect(1, 6);
    chk("f1_empty", bif.o_setipnum_valid[1], 0);

    // response back-pressure, with a competing request that must be ignored
    bus_req(S_BASE + STRIDE, 1'b1, 32'd3);
    bif.i_req_valid = 1'b1;
    bif.i_req_addr  = M_BASE;
    bif.i_req_wdata = 32'd9;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_req_ready", bif.o_req_ready, 0);
      chk("bp_rsp_valid", bif.o_rsp_valid, 1);
      chk("bp_rsp_err", bif.o_rsp_err, 0);
    end
    bif.i_req_valid = 1'b0;
    chk("bp_no_enq", bif.o_setipnum_valid[0], 0);

    // asynchronous reset while a response is pending and a FIFO holds data
    chk("pre_rst_valid", bif.o_setipnum_valid[2], 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_req_ready", bif.o_req_ready, 0);
    chk("rst_rsp_valid", bif.o_rsp_valid, 0);
    chk("rst_rsp_err", bif.o_rsp_err, 0);
    chk("rst_head_valid", bif.o_setipnum_valid, 0);
    chk("rst_head_id", bif.o_setipnum, 0);
    chk("rst_ovf", bif.o_overflow, 0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_rst_empty", bif.o_setipnum_valid[2], 0);
    chk("post_rst_ready", bif.o_req_ready, 1);

    // randomized traffic
    for (int c = 0; c < RAND_CYCLES; c++) begin
      bif.i_req_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0:       bif.i_req_addr = M_BASE;
        1, 2, 3: bif.i_req_addr = S_BASE + STRIDE * $urandom_range(0, 2);
        4:       bif.i_req_addr = S_BASE + 3 * STRIDE;
        5:       bif.i_req_addr = M_BASE + 32'h4;
        default: bif.i_req_addr = $urandom;
      endcase
      bif.i_req_we = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       bif.i_req_wdata = 32'h0;
        1:       bif.i_req_wdata = 32'(NR_SRC + $urandom_range(0, 5));
        2:       bif.i_req_wdata = ($urandom << NR_SRC_LEN) | 32'($urandom_range(1, NR_SRC - 1));
        default: bif.i_req_wdata = 32'($urandom_range(1, NR_SRC - 1));
      endcase
      bif.i_rsp_ready = ($urandom_range(0, 3) != 0);
      for (int f = 0; f < NF; f++) begin
        bif.i_setipnum_ready[f] = ($urandom_range(0, 3) == 0);
        bif.i_overflow_clr[f]   = ($urandom_range(0, 15) == 0);
      end
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
